// File: rtl/commit_monitor_if.sv
// Per-lane commit record bundle: NLANE lanes of pc/instr/GPR-write/skip, lane 0 oldest.
// The producer uses the master modport and the consumer uses the slave modport.
interface commit_monitor_if #(
  parameter int NLANE = 2,
  parameter int XLEN  = 64
);
  logic [NLANE-1:0]      valid;
  logic [NLANE*XLEN-1:0] pc;
  logic [NLANE*32-1:0]   instr;
  logic [NLANE-1:0]      wen;
  logic [NLANE*5-1:0]    wdest;
  logic [NLANE*XLEN-1:0] wdata;
  logic [NLANE-1:0]      skip;

  modport master (output valid, pc, instr, wen, wdest, wdata, skip);
  modport slave  (input  valid, pc, instr, wen, wdest, wdata, skip);
endinterface

// File: rtl/commit_monitor.sv
// N-lane retire monitor: registers commit records, counts cycles/instructions, traps on halt.
// Optional no-commit watchdog trap is enabled by defining COMMIT_MON_WDOG_EN.
//
// state  | meaning
// RUN    | accepting commits, counters advancing
// HALTED | trap outputs held, inputs ignored until reset
module commit_monitor #(
  parameter int NLANE = 2,
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
`ifdef COMMIT_MON_WDOG_EN
  , parameter int WDOG_LIMIT = 4096
`endif
) (
  input  logic                 clk,
  input  logic                 resetn,
  commit_monitor_if.slave      retire,
  commit_monitor_if.master     commit,
  input  logic [XLEN-1:0]      a0_value,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instr_cnt,
  output logic                 trap_valid,
  output logic [XLEN-1:0]      trap_code,
  output logic [XLEN-1:0]      trap_pc,
  output logic                 halted
);

  localparam logic [31:0] HALT_INSTR = 32'h0005006b;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;
  state_t state;

  logic [NLANE-1:0]      accept;
  logic [NLANE-1:0]      acc_wen;
  logic [NLANE*XLEN-1:0] acc_pc;
  logic [NLANE*32-1:0]   acc_instr;
  logic [NLANE*5-1:0]    acc_wdest;
  logic [NLANE*XLEN-1:0] acc_wdata;
  logic [NLANE-1:0]      acc_skip;
  logic [CNT_W-1:0]      acc_cnt;
  logic                  halt_hit;
  logic [XLEN-1:0]       halt_pc;
  logic [XLEN-1:0]       halt_code;
  logic [XLEN-1:0]       last_acc_pc;

  logic [NLANE-1:0]      out_valid_q;
  logic [NLANE-1:0]      out_wen_q;
  logic [NLANE*XLEN-1:0] out_pc_q;
  logic [NLANE*32-1:0]   out_instr_q;
  logic [NLANE*5-1:0]    out_wdest_q;
  logic [NLANE*XLEN-1:0] out_wdata_q;
  logic [NLANE-1:0]      out_skip_q;

  // Walk lanes in program order; everything younger than the first halt is dropped.
  always_comb begin
    accept      = '0;
    acc_wen     = '0;
    acc_pc      = '0;
    acc_instr   = '0;
    acc_wdest   = '0;
    acc_wdata   = '0;
    acc_skip    = '0;
    acc_cnt     = '0;
    halt_hit    = 1'b0;
    halt_pc     = '0;
    halt_code   = a0_value;
    last_acc_pc = '0;
    for (int i = 0; i < NLANE; i++) begin
      if (retire.valid[i] && !halt_hit) begin
        accept[i]                 = 1'b1;
        acc_cnt                   = acc_cnt + CNT_W'(1);
        acc_wen[i]                = retire.wen[i] && (retire.wdest[i*5 +: 5] != 5'd0);
        acc_pc[i*XLEN +: XLEN]    = retire.pc[i*XLEN +: XLEN];
        acc_instr[i*32 +: 32]     = retire.instr[i*32 +: 32];
        acc_wdest[i*5 +: 5]       = retire.wdest[i*5 +: 5];
        acc_wdata[i*XLEN +: XLEN] = retire.wdata[i*XLEN +: XLEN];
        acc_skip[i]               = retire.skip[i];
        last_acc_pc               = retire.pc[i*XLEN +: XLEN];
        if (retire.instr[i*32 +: 32] == HALT_INSTR) begin
          halt_hit = 1'b1;
          halt_pc  = retire.pc[i*XLEN +: XLEN];
        end else if (retire.wen[i] && (retire.wdest[i*5 +: 5] == 5'd10)) begin
          halt_code = retire.wdata[i*XLEN +: XLEN];
        end
      end
    end
  end

`ifdef COMMIT_MON_WDOG_EN
  logic [31:0]     idle_cnt;
  logic [XLEN-1:0] wdog_pc;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= RUN;
      out_valid_q <= '0;
      out_wen_q   <= '0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_wdest_q <= '0;
      out_wdata_q <= '0;
      out_skip_q  <= '0;
      cycle_cnt   <= '0;
      instr_cnt   <= '0;
      trap_valid  <= 1'b0;
      trap_code   <= '0;
      trap_pc     <= '0;
      halted      <= 1'b0;
`ifdef COMMIT_MON_WDOG_EN
      idle_cnt    <= '0;
      wdog_pc     <= '0;
`endif
    end else begin
      case (state)
        RUN: begin
          out_valid_q <= accept;
          out_wen_q   <= acc_wen;
          out_pc_q    <= acc_pc;
          out_instr_q <= acc_instr;
          out_wdest_q <= acc_wdest;
          out_wdata_q <= acc_wdata;
          out_skip_q  <= acc_skip;
          cycle_cnt   <= cycle_cnt + CNT_W'(1);
          instr_cnt   <= instr_cnt + acc_cnt;
`ifdef COMMIT_MON_WDOG_EN
          if (|accept) begin
            idle_cnt <= '0;
            wdog_pc  <= last_acc_pc;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
`endif
          if (halt_hit) begin
            state      <= HALTED;
            trap_valid <= 1'b1;
            halted     <= 1'b1;
            trap_code  <= halt_code;
            trap_pc    <= halt_pc;
          end
`ifdef COMMIT_MON_WDOG_EN
          else if (!(|accept) && (idle_cnt == 32'(WDOG_LIMIT - 1))) begin
            state      <= HALTED;
            trap_valid <= 1'b1;
            halted     <= 1'b1;
            trap_code  <= XLEN'(1);
            trap_pc    <= wdog_pc;
          end
`endif
        end
        HALTED: begin
          out_valid_q <= '0;
          out_wen_q   <= '0;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifndef COMMIT_MON_WDOG_EN
  logic unused_last_pc;
  assign unused_last_pc = ^last_acc_pc;
`endif

  assign commit.valid = out_valid_q;
  assign commit.wen   = out_wen_q;
  assign commit.pc    = out_pc_q;
  assign commit.instr = out_instr_q;
  assign commit.wdest = out_wdest_q;
  assign commit.wdata = out_wdata_q;
  assign commit.skip  = out_skip_q;

endmodule
